safe_bus_arbiter: RTL and testbench
===================================

SAFE_BUS_ARBITER -- requirements
Module: safe_bus_arbiter

Interface
REQ-001 Parameter NHARTS, default 3: number of hart request ports.
REQ-002 Parameter TIMEOUT, default 256: cycles allowed in RESP before forced error completion; range 2..65535.
REQ-003 clk_i  in  1  sole clock, all state on rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 single_bus_i  in  1  lockstep mode, only the master hart reaches the bus and responses are broadcast.
REQ-006 master_core_i  in  NHARTS  master hart select (one-hot expected).
REQ-007 req_i, we_i  in  NHARTS each  per-hart request and write-enable.
REQ-008 be_i  in  NHARTS*4; addr_i, wdata_i  in  NHARTS*32  per-hart byte-enable, address and write data.
REQ-009 gnt_o, rvalid_o, err_o  out  NHARTS each  per-hart grant, response valid and error.
REQ-010 rdata_o  out  32  response data, shared by all harts.
REQ-011 bus_req_o, bus_we_o  out  1; bus_be_o  out  4; bus_addr_o, bus_wdata_o  out  32  shared bus request.
REQ-012 bus_gnt_i, bus_rvalid_i  in  1; bus_rdata_i  in  32  shared bus handshake and response.
REQ-013 owner_o  out  NHARTS  one-hot owner of the current transaction; busy_o  out  1  state is not IDLE.

Function
REQ-014 FSM states: IDLE, ADDR, RESP. At most one outstanding bus transaction.
REQ-015 IDLE: if any eligible req_i is high, the arbiter SHALL latch the winner index, we, be, addr and wdata, set owner_o and go to ADDR the next cycle.
REQ-016 Eligibility when single_bus_i=0: all harts. Round-robin, first requester at or after pointer rr_ptr, wrapping from NHARTS-1 to 0.
REQ-017 Eligibility when single_bus_i=1: only the master, meaning the lowest set index of master_core_i, or hart 0 if master_core_i is 0. rr_ptr is not used in this mode.
REQ-018 single_bus_i and master_core_i are sampled only in IDLE. Mode is fixed for the whole transaction.
REQ-019 ADDR: bus_req_o=1 with the latched fields, held stable until bus_gnt_i. On bus_gnt_i, gnt_o pulses in that same cycle and the FSM goes to RESP.
REQ-020 Gnt target: the owner only, or all NHARTS bits if the transaction was latched in single-bus mode.
REQ-021 Hart-to-bus latency: req_i high in IDLE at cycle N gives bus_req_o=1 at N+1.
REQ-022 RESP: on bus_rvalid_i, rvalid_o pulses the same cycle to the gnt target set, with rdata_o=bus_rdata_i. The FSM returns to IDLE.
REQ-023 rr_ptr advances to (owner index+1) mod NHARTS on completion of a non-single-bus transaction.
REQ-024 bus_rvalid_i in IDLE or ADDR is ignored. bus_gnt_i outside ADDR is ignored.
REQ-025 Timeout: a 16-bit counter clears on entry to RESP and increments each RESP cycle. If it reaches TIMEOUT-1 without bus_rvalid_i, the arbiter SHALL pulse rvalid_o and err_o to the gnt target with rdata_o=0, then return to IDLE.
REQ-026 bus_rvalid_i in the same cycle as the timeout is a normal completion with err_o=0.
REQ-027 rdata_o is 0 whenever rvalid_o is 0.
REQ-028 Requests arriving in ADDR or RESP are not captured. The hart keeps req_i high (gnt not yet given) and is arbitrated on the next IDLE cycle.
REQ-029 The arbiter returns to IDLE for one cycle between transactions: maximum throughput is one transaction per 3 cycles.

Reset
REQ-030 While rst_i=1: state=IDLE, rr_ptr=0, counter=0, latched fields=0.
REQ-031 While rst_i=1: all outputs 0, including bus_req_o, gnt_o, rvalid_o, err_o, owner_o and busy_o.
REQ-032 Reset mid-transaction abandons it without any gnt_o or rvalid_o pulse. bus_rvalid_i after reset is ignored per REQ-024.

Structure
REQ-033 The state enum (IDLE/ADDR/RESP) and a HART_DW=32 constant SHALL live in shared package safe_pkg, alongside the safe-mode FSM types.
REQ-034 The rotate-and-pick logic SHALL be one sub-module, safe_rr_pick: inputs request vector and pointer, outputs one-hot winner and a valid flag, purely combinational.

Verification
REQ-035 Scenario 1, round-robin fairness: single_bus_i=0, all three req_i held high, each bus transaction takes gnt 1 cycle and rvalid 2 cycles later. Owner sequence SHALL be 0,1,2,0.
REQ-036 Scenario 2, lockstep broadcast: single_bus_i=1, master_core_i=3'b010, all req_i high, addr_i[1]=0x100. bus_addr_o SHALL be 0x100, gnt_o=3'b111 and rvalid_o=3'b111 with the same rdata.
REQ-037 Scenario 3, timeout: TIMEOUT=8, bus never asserts rvalid. err_o[owner] and rvalid_o[owner] SHALL pulse 8 cycles after entry to RESP, rdata_o=0, then IDLE.
REQ-038 Scenario 4, reset mid-RESP: rst_i pulsed, then bus_rvalid_i=1. There SHALL be no rvalid_o pulse and rr_ptr=0.
REQ-039 Scenario 5, master fallback: single_bus_i=1, master_core_i=0, req_i=3'b110. Nothing SHALL be granted until req_i[0]=1; hart 0 is then served.
REQ-040 Scenario 6, mode-change isolation: single_bus_i toggles 0->1 during RESP. The current transaction SHALL complete to its owner only, and the new mode applies from the next IDLE.

Source files
------------

// File: rtl/safe_pkg.sv
// Shared types and constants for the safe bus arbiter: FSM state encoding and
// the hart data/byte-enable widths.
package safe_pkg;

   localparam int HART_DW = 32;
   localparam int BE_W    = HART_DW / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      RESP = 2'd2
   } arb_state_e;

endpackage

// File: rtl/safe_rr_pick.sv
// Combinational rotate-and-pick: returns the first requester found at or after
// ptr_i, wrapping from N-1 back to 0, as a one-hot vector.
module safe_rr_pick #(
   parameter int N     = 3,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_o,
   output logic             valid_o
);

   function automatic int rot_idx(input logic [PTR_W-1:0] p, input int off);
      int s;
      s = int'(p) + off;
      return (s >= N) ? s - N : s;
   endfunction

   always_comb begin
      gnt_o   = '0;
      valid_o = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!valid_o && req_i[rot_idx(ptr_i, i)]) begin
            gnt_o[rot_idx(ptr_i, i)] = 1'b1;
            valid_o                  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/safe_bus_arbiter.sv
// Arbitrates NHARTS hart request ports onto one shared bus with a single
// outstanding transaction, round-robin or lockstep (master-only, broadcast) mode.
module safe_bus_arbiter
   import safe_pkg::*;
#(
   parameter int NHARTS  = 3,
   parameter int TIMEOUT = 256
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      single_bus_i,
   input  logic [NHARTS-1:0]         master_core_i,
   input  logic [NHARTS-1:0]         req_i,
   input  logic [NHARTS-1:0]         we_i,
   input  logic [NHARTS*BE_W-1:0]    be_i,
   input  logic [NHARTS*HART_DW-1:0] addr_i,
   input  logic [NHARTS*HART_DW-1:0] wdata_i,
   output logic [NHARTS-1:0]         gnt_o,
   output logic [NHARTS-1:0]         rvalid_o,
   output logic [NHARTS-1:0]         err_o,
   output logic [HART_DW-1:0]        rdata_o,
   output logic                      bus_req_o,
   output logic                      bus_we_o,
   output logic [BE_W-1:0]           bus_be_o,
   output logic [HART_DW-1:0]        bus_addr_o,
   output logic [HART_DW-1:0]        bus_wdata_o,
   input  logic                      bus_gnt_i,
   input  logic                      bus_rvalid_i,
   input  logic [HART_DW-1:0]        bus_rdata_i,
   output logic [NHARTS-1:0]         owner_o,
   output logic                      busy_o
);

   localparam int               PTR_W    = (NHARTS > 1) ? $clog2(NHARTS) : 1;
   localparam logic [15:0]      TO_LAST  = 16'(TIMEOUT - 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NHARTS - 1);

   arb_state_e         state_q, state_d;
   logic [PTR_W-1:0]   owner_idx_q, owner_idx_d;
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic               bcast_q, bcast_d;
   logic               we_q, we_d;
   logic [BE_W-1:0]    be_q, be_d;
   logic [HART_DW-1:0] addr_q, addr_d;
   logic [HART_DW-1:0] wdata_q, wdata_d;
   logic [15:0]        cnt_q, cnt_d;

   logic [NHARTS-1:0]  master_oh, pick_req, pick_gnt, owner_oh, target;
   logic [PTR_W-1:0]   pick_ptr, pick_idx;
   logic               pick_valid;

   // Lowest set bit of master_core_i; hart 0 when no bit is set.
   always_comb begin
      master_oh    = '0;
      master_oh[0] = 1'b1;
      for (int i = NHARTS - 1; i >= 0; i--) begin
         if (master_core_i[i]) begin
            master_oh    = '0;
            master_oh[i] = 1'b1;
         end
      end
   end

   assign pick_req = single_bus_i ? (req_i & master_oh) : req_i;
   assign pick_ptr = single_bus_i ? '0 : rr_ptr_q;

   safe_rr_pick #(.N(NHARTS), .PTR_W(PTR_W)) u_pick (
      .req_i   (pick_req),
      .ptr_i   (pick_ptr),
      .gnt_o   (pick_gnt),
      .valid_o (pick_valid)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NHARTS; i++) begin
         if (pick_gnt[i]) pick_idx = PTR_W'(i);
      end
      owner_oh              = '0;
      owner_oh[owner_idx_q] = 1'b1;
   end

   // Lockstep transactions grant and respond to every hart at once.
   assign target = bcast_q ? '1 : owner_oh;

   always_comb begin
      state_d     = state_q;
      owner_idx_d = owner_idx_q;
      rr_ptr_d    = rr_ptr_q;
      bcast_d     = bcast_q;
      we_d        = we_q;
      be_d        = be_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cnt_d       = cnt_q;
      gnt_o       = '0;
      rvalid_o    = '0;
      err_o       = '0;
      rdata_o     = '0;

      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               owner_idx_d = pick_idx;
               bcast_d     = single_bus_i;
               we_d        = we_i[pick_idx];
               be_d        = be_i[pick_idx*BE_W +: BE_W];
               addr_d      = addr_i[pick_idx*HART_DW +: HART_DW];
               wdata_d     = wdata_i[pick_idx*HART_DW +: HART_DW];
               state_d     = ADDR;
            end
         end
         ADDR: begin
            if (bus_gnt_i) begin
               gnt_o   = target;
               cnt_d   = '0;
               state_d = RESP;
            end
         end
         RESP: begin
            // A real response wins over a timeout landing in the same cycle.
            if (bus_rvalid_i || cnt_q == TO_LAST) begin
               rvalid_o = target;
               if (bus_rvalid_i) rdata_o = bus_rdata_i;
               else              err_o   = target;
               state_d = IDLE;
               if (!bcast_q) rr_ptr_d = (owner_idx_q == PTR_LAST) ? '0 : owner_idx_q + 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (rst_i) begin
         gnt_o    = '0;
         rvalid_o = '0;
         err_o    = '0;
         rdata_o  = '0;
      end
   end

   assign busy_o      = !rst_i && (state_q != IDLE);
   assign bus_req_o   = !rst_i && (state_q == ADDR);
   assign owner_o     = busy_o ? owner_oh : '0;
   assign bus_we_o    = bus_req_o & we_q;
   assign bus_be_o    = bus_req_o ? be_q : '0;
   assign bus_addr_o  = bus_req_o ? addr_q : '0;
   assign bus_wdata_o = bus_req_o ? wdata_q : '0;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         owner_idx_q <= '0;
         rr_ptr_q    <= '0;
         bcast_q     <= 1'b0;
         we_q        <= 1'b0;
         be_q        <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         owner_idx_q <= owner_idx_d;
         rr_ptr_q    <= rr_ptr_d;
         bcast_q     <= bcast_d;
         we_q        <= we_d;
         be_q        <= be_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cnt_q       <= cnt_d;
      end
   end

endmodule

// File: tb/tb_safe_bus_arbiter.sv
// Directed, table-driven bench for safe_bus_arbiter (3 harts, TIMEOUT=8):
// each record is one clock cycle of stimulus with the outputs expected in it.
module tb_safe_bus_arbiter;

   localparam bit          O  = 1'b0;
   localparam bit          I  = 1'b1;
   localparam logic [31:0] Z  = 32'h0;
   localparam logic [2:0]  N3 = 3'b000;
   localparam logic [31:0] D0 = 32'hDEAD_0000;
   localparam logic [31:0] D1 = 32'h1111_1111;
   localparam logic [31:0] D2 = 32'h2222_2222;
   localparam logic [31:0] D3 = 32'h3333_3333;

   logic        clk;
   logic        rst, single_bus, bus_gnt, bus_rvalid;
   logic [2:0]  master_core, req, we;
   logic [11:0] be;
   logic [95:0] addr, wdata;
   logic [31:0] bus_rdata;
   logic [2:0]  gnt, rvalid, err, owner;
   logic [31:0] rdata, bus_addr, bus_wdata;
   logic        bus_req, bus_we, busy;
   logic [3:0]  bus_be;

   logic [31:0] hart_addr  [3];
   logic [31:0] hart_wdata [3];
   logic [3:0]  hart_be    [3];
   logic        hart_we    [3];

   int n_checks = 0;
   int n_err    = 0;

   typedef struct {
      logic        rst, sb;
      logic [2:0]  mc, req;
      logic        bg, brv;
      logic [31:0] brd;
      logic        e_breq;
      logic [31:0] e_addr;
      logic [2:0]  e_gnt, e_rv, e_err;
      logic [31:0] e_rd;
      logic [2:0]  e_own;
      logic        e_busy;
   } vec_t;

   vec_t tbl[$];

   safe_bus_arbiter #(.NHARTS(3), .TIMEOUT(8)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .single_bus_i  (single_bus),
      .master_core_i (master_core),
      .req_i         (req),
      .we_i          (we),
      .be_i          (be),
      .addr_i        (addr),
      .wdata_i       (wdata),
      .gnt_o         (gnt),
      .rvalid_o      (rvalid),
      .err_o         (err),
      .rdata_o       (rdata),
      .bus_req_o     (bus_req),
      .bus_we_o      (bus_we),
      .bus_be_o      (bus_be),
      .bus_addr_o    (bus_addr),
      .bus_wdata_o   (bus_wdata),
      .bus_gnt_i     (bus_gnt),
      .bus_rvalid_i  (bus_rvalid),
      .bus_rdata_i   (bus_rdata),
      .owner_o       (owner),
      .busy_o        (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mk(bit r, bit sb, logic [2:0] mc, logic [2:0] rq, bit bg, bit brv,
                               logic [31:0] brd, bit e_breq, logic [31:0] e_addr, logic [2:0] e_gnt,
                               logic [2:0] e_rv, logic [2:0] e_err, logic [31:0] e_rd,
                               logic [2:0] e_own, bit e_busy);
      vec_t v;
      v.rst = r; v.sb = sb; v.mc = mc; v.req = rq; v.bg = bg; v.brv = brv; v.brd = brd;
      v.e_breq = e_breq; v.e_addr = e_addr; v.e_gnt = e_gnt; v.e_rv = e_rv; v.e_err = e_err;
      v.e_rd = e_rd; v.e_own = e_own; v.e_busy = e_busy;
      return v;
   endfunction

   task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s row=%0d got=%h expected=%h", name, row, act, exp);
      end
   endtask

   // Drive one cycle of stimulus, check outputs at the falling edge, then advance.
   task automatic apply(input vec_t v, input int row);
      int h;
      rst         = v.rst;
      single_bus  = v.sb;
      master_core = v.mc;
      req         = v.req;
      bus_gnt     = v.bg;
      bus_rvalid  = v.brv;
      bus_rdata   = v.brd;
      @(negedge clk);
      chk("bus_req", row, 32'(bus_req), 32'(v.e_breq));
      chk("gnt", row, 32'(gnt), 32'(v.e_gnt));
      chk("rvalid", row, 32'(rvalid), 32'(v.e_rv));
      chk("err", row, 32'(err), 32'(v.e_err));
      chk("rdata", row, rdata, v.e_rd);
      chk("owner", row, 32'(owner), 32'(v.e_own));
      chk("busy", row, 32'(busy), 32'(v.e_busy));
      if (v.e_breq) begin
         h = 0;
         for (int k = 0; k < 3; k++) if (v.e_own[k]) h = k;
         chk("bus_addr", row, bus_addr, v.e_addr);
         chk("bus_wdata", row, bus_wdata, hart_wdata[h]);
         chk("bus_be", row, 32'(bus_be), 32'(hart_be[h]));
         chk("bus_we", row, 32'(bus_we), 32'(hart_we[h]));
      end
      if (rvalid != 3'b000)
         $display("txn row=%0d owner=%b rvalid=%b err=%b rdata=%h", row, owner, rvalid, err, rdata);
      @(posedge clk);
      #1;
   endtask

   initial begin
      hart_addr  = '{32'h0000_0080, 32'h0000_0100, 32'h0000_0180};
      hart_wdata = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002};
      hart_be    = '{4'h1, 4'hF, 4'hC};
      hart_we    = '{1'b0, 1'b1, 1'b0};
      for (int h = 0; h < 3; h++) begin
         addr[h*32 +: 32]  = hart_addr[h];
         wdata[h*32 +: 32] = hart_wdata[h];
         be[h*4 +: 4]      = hart_be[h];
         we[h]             = hart_we[h];
      end

      // Round-robin fairness, with stray bus_gnt/bus_rvalid outside their states.
      tbl.push_back(mk(I,O,3'b001,3'b111,O,O,Z,   O,Z,N3,N3,N3,Z,N3,O));
      tbl.push_back(mk(O,O,3'b001,3'b111,O,O,Z,   O,Z,N3,N3,N3,Z,N3,O));
      tbl.push_back(mk(O,O,3'b001,3'b111,I,O,Z,   I,32'h080,3'b001,N3,N3,Z,3'b001,I));
      tbl.push_back(mk(O,O,3'b001,3'b111,O,O,Z,   O,Z,N3,N3,N3,Z,3'b001,I));
      tbl.push_back(mk(O,O,3'b001,3'b111,O,I,D0,  O,Z,N3,3'b001,N3,D0,3'b001,I));
      tbl.push_back(mk(O,O,3'b001,3'b111,O,O,Z,   O,Z,N3,N3,N3,Z,N3,O));
      tbl.push_back(mk(O,O,3'b001,3'b111,I,O,Z,   I,32'h100,3'b010,N3,N3,Z,3'b010,I));
      tbl.push_back(mk(O,O,3'b001,3'b111,O,O,Z,   O,Z,N3,N3,N3,Z,3'b010,I));
      tbl.push_back(mk(O,O,3'b001,3'b111,O,I,D1,  O,Z,N3,3'b010,N3,D1,3'b010,I));
      tbl.push_back(mk(O,O,3'b001,3'b111,O,I,D3,  O,Z,N3,N3,N3,Z,N3,O));
      tbl.push_back(mk(O,O,3'b001,3'b111,I,O,Z,   I,32'h180,3'b100,N3,N3,Z,3'b100,I));
      tbl.push_back(mk(O,O,3'b001,3'b111,O,O,Z,   O,Z,N3,N3,N3,Z,3'b100,I));
      tbl.push_back(mk(O,O,3'b001,3'b111,O,I,D2,  O,Z,N3,3'b100,N3,D2,3'b100,I));
      tbl.push_back(mk(O,O,3'b001,3'b111,I,O,Z,   O,Z,N3,N3,N3,Z,N3,O));
      tbl.push_back(mk(O,O,3'b001,3'b111,O,I,D3,  I,32'h080,N3,N3,N3,Z,3'b001,I));
      tbl.push_back(mk(O,O,3'b001,3'b111,I,O,Z,   I,32'h080,3'b001,N3,N3,Z,3'b001,I));
      tbl.push_back(mk(O,O,3'b001,3'b111,O,I,D0,  O,Z,N3,3'b001,N3,D0,3'b001,I));
      // Lockstep broadcast from master hart 1; rr pointer must stay at 1.
      tbl.push_back(mk(O,I,3'b010,3'b111,O,O,Z,   O,Z,N3,N3,N3,Z,N3,O));
      tbl.push_back(mk(O,I,3'b010,3'b111,I,O,Z,   I,32'h100,3'b111,N3,N3,Z,3'b010,I));
      tbl.push_back(mk(O,I,3'b010,3'b111,O,I,32'hCAFEF00D, O,Z,N3,3'b111,N3,32'hCAFEF00D,3'b010,I));
      tbl.push_back(mk(O,O,3'b010,3'b111,O,O,Z,   O,Z,N3,N3,N3,Z,N3,O));
      tbl.push_back(mk(O,O,3'b010,3'b111,I,O,Z,   I,32'h100,3'b010,N3,N3,Z,3'b010,I));
      tbl.push_back(mk(O,O,3'b010,3'b111,O,I,D1,  O,Z,N3,3'b010,N3,D1,3'b010,I));
      // Master fallback to hart 0 when master_core_i is zero.
      tbl.push_back(mk(O,I,3'b000,3'b110,O,O,Z,   O,Z,N3,N3,N3,Z,N3,O));
      tbl.push_back(mk(O,I,3'b000,3'b110,O,O,Z,   O,Z,N3,N3,N3,Z,N3,O));
      tbl.push_back(mk(O,I,3'b000,3'b111,O,O,Z,   O,Z,N3,N3,N3,Z,N3,O));
      tbl.push_back(mk(O,I,3'b000,3'b111,I,O,Z,   I,32'h080,3'b111,N3,N3,Z,3'b001,I));
      tbl.push_back(mk(O,I,3'b000,3'b111,O,I,D2,  O,Z,N3,3'b111,N3,D2,3'b001,I));
      // Mode change during RESP: completes to owner only, lockstep next time.
      tbl.push_back(mk(O,O,3'b010,3'b111,O,O,Z,   O,Z,N3,N3,N3,Z,N3,O));
      tbl.push_back(mk(O,O,3'b010,3'b111,I,O,Z,   I,32'h180,3'b100,N3,N3,Z,3'b100,I));
      tbl.push_back(mk(O,I,3'b010,3'b111,O,O,Z,   O,Z,N3,N3,N3,Z,3'b100,I));
      tbl.push_back(mk(O,I,3'b010,3'b111,O,I,D3,  O,Z,N3,3'b100,N3,D3,3'b100,I));
      tbl.push_back(mk(O,I,3'b010,3'b111,O,O,Z,   O,Z,N3,N3,N3,Z,N3,O));
      tbl.push_back(mk(O,I,3'b010,3'b111,I,O,Z,   I,32'h100,3'b111,N3,N3,Z,3'b010,I));
      tbl.push_back(mk(O,I,3'b010,3'b111,O,I,D0,  O,Z,N3,3'b111,N3,D0,3'b010,I));

      rst = 1'b1; single_bus = 1'b0; master_core = 3'b001; req = 3'b000;
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
      #1;
      foreach (tbl[r]) apply(tbl[r], r);

      // Timeout: gnt, then 7 silent RESP cycles, error completion on the 8th.
      apply(mk(O,O,3'b001,3'b001,O,O,Z, O,Z,N3,N3,N3,Z,N3,O), 100);
      apply(mk(O,O,3'b001,3'b001,I,O,Z, I,32'h080,3'b001,N3,N3,Z,3'b001,I), 101);
      for (int k = 0; k < 7; k++)
         apply(mk(O,O,3'b001,3'b001,O,O,32'hFFFFFFFF, O,Z,N3,N3,N3,Z,3'b001,I), 110 + k);
      apply(mk(O,O,3'b001,3'b001,O,O,32'hFFFFFFFF, O,Z,N3,3'b001,3'b001,Z,3'b001,I), 117);
      apply(mk(O,O,3'b001,3'b000,O,O,Z, O,Z,N3,N3,N3,Z,N3,O), 118);

      // bus_rvalid coinciding with the timeout cycle is a normal completion.
      apply(mk(O,O,3'b001,3'b001,O,O,Z, O,Z,N3,N3,N3,Z,N3,O), 200);
      apply(mk(O,O,3'b001,3'b001,I,O,Z, I,32'h080,3'b001,N3,N3,Z,3'b001,I), 201);
      for (int k = 0; k < 7; k++)
         apply(mk(O,O,3'b001,3'b001,O,O,Z, O,Z,N3,N3,N3,Z,3'b001,I), 210 + k);
      apply(mk(O,O,3'b001,3'b001,O,I,32'h12345678, O,Z,N3,3'b001,N3,32'h12345678,3'b001,I), 217);
      apply(mk(O,O,3'b001,3'b000,O,O,Z, O,Z,N3,N3,N3,Z,N3,O), 218);

      // Reset mid-RESP: late bus_rvalid ignored, pointer back to hart 0.
      apply(mk(O,O,3'b001,3'b111,O,O,Z, O,Z,N3,N3,N3,Z,N3,O), 300);
      apply(mk(O,O,3'b001,3'b111,I,O,Z, I,32'h100,3'b010,N3,N3,Z,3'b010,I), 301);
      apply(mk(O,O,3'b001,3'b111,O,O,Z, O,Z,N3,N3,N3,Z,3'b010,I), 302);
      apply(mk(I,O,3'b001,3'b111,O,I,D1, O,Z,N3,N3,N3,Z,N3,O), 303);
      apply(mk(O,O,3'b001,3'b000,O,I,D0, O,Z,N3,N3,N3,Z,N3,O), 304);
      apply(mk(O,O,3'b001,3'b111,O,O,Z, O,Z,N3,N3,N3,Z,N3,O), 305);
      apply(mk(O,O,3'b001,3'b111,I,O,Z, I,32'h080,3'b001,N3,N3,Z,3'b001,I), 306);
      apply(mk(O,O,3'b001,3'b000,O,I,D2, O,Z,N3,3'b001,N3,D2,3'b001,I), 307);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
